// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter: FSM encoding, 7-segment codes
// and the decade-weight helper used by the BCD converter.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    COUNT   = 2'd0,
    CONVERT = 2'd1,
    LATCH   = 2'd2
  } state_e;

  // Segment patterns, bit0 = a .. bit6 = g, active high.
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < n) p = p * 10;
    end
    return p;
  endfunction

endpackage

// File: rtl/freq_meter_seven_segment.sv
// BCD to 7-segment decoder; non-decimal codes blank the digit.
module seven_segment
  import freq_meter_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/freq_meter.sv
// Gated-window frequency meter: counts rising edges over a programmable window,
// converts the count to BCD by repeated subtraction and drives a muxed display.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int DIGITS         = 3,
  parameter int PERIOD_BITS    = 16,
  parameter int DEFAULT_PERIOD = 1200,
  parameter int MUX_BITS       = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   signal,
  input  logic [PERIOD_BITS-1:0] period,
  input  logic                   period_load,
  output logic [6:0]             segments,
  output logic [DIGITS-1:0]      digit,
  output logic                   overflow,
  output logic                   update
);

  localparam int unsigned MAX_COUNT = pow10(DIGITS) - 1;
  localparam logic [1:0]  LAST_IDX  = 2'(DIGITS - 1);

  state_e                 r_state;
  logic [2:0]             r_sync;
  logic [PERIOD_BITS-1:0] r_cycles, r_edges, r_period;
  logic [1:0]             r_idx, r_dig_idx;
  logic [3:0]             r_work [4];
  logic [3:0]             r_disp [4];
  logic                   r_ovf_work, r_ovf, r_update;
  logic [MUX_BITS-1:0]    r_refresh;
  logic [DIGITS-1:0]      r_digit;
  logic [6:0]             r_segments;

  state_e                 w_state_next;
  logic                   w_edge, w_terminal, w_ge, w_ovf_in, w_wrap;
  logic [PERIOD_BITS-1:0] w_edges_inc, w_weight;
  logic [1:0]             w_idx_next;
  logic [3:0]             w_bcd_sel;
  logic [6:0]             w_seg;

  assign w_edge      = r_sync[1] & ~r_sync[2];
  assign w_edges_inc = r_edges + PERIOD_BITS'(w_edge);
  assign w_terminal  = (r_cycles == r_period - PERIOD_BITS'(1));
  assign w_weight    = PERIOD_BITS'(pow10(32'(r_idx)));
  assign w_ge        = (r_edges >= w_weight);
  assign w_ovf_in    = (32'(w_edges_inc) > MAX_COUNT);
  assign w_wrap      = &r_refresh;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_next = COUNT;
    case (r_state)
      COUNT:   w_state_next = w_terminal ? CONVERT : COUNT;
      CONVERT: w_state_next = (r_ovf_work || (!w_ge && r_idx == 2'd0)) ? LATCH : CONVERT;
      default: w_state_next = COUNT;
    endcase
    if (period_load) w_state_next = COUNT;
  end

  // Segments are decoded from the digit that will be selected next cycle,
  // including a result being latched this cycle, so both outputs move together.
  always_comb begin
    w_idx_next = r_dig_idx;
    if (w_wrap) w_idx_next = (r_dig_idx == LAST_IDX) ? 2'd0 : r_dig_idx + 2'd1;
    w_bcd_sel = (r_state == LATCH && !period_load) ? r_work[w_idx_next] : r_disp[w_idx_next];
  end

  seven_segment u_seven_segment (
    .i_bcd (w_bcd_sel),
    .o_seg (w_seg)
  );

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= COUNT;
      r_sync     <= '0;
      r_cycles   <= '0;
      r_edges    <= '0;
      r_period   <= PERIOD_BITS'(DEFAULT_PERIOD);
      r_idx      <= '0;
      r_ovf_work <= 1'b0;
      r_ovf      <= 1'b0;
      r_update   <= 1'b0;
      r_refresh  <= '0;
      r_dig_idx  <= '0;
      r_digit    <= DIGITS'(1);
      r_segments <= SEG_0;
      // NOTE: the digit arrays are tiny and visible on the display, so they are reset like flops.
      for (int d = 0; d < 4; d++) begin
        r_work[d] <= '0;
        r_disp[d] <= '0;
      end
    end else begin
      r_sync     <= {r_sync[1:0], signal};
      r_state    <= w_state_next;
      r_update   <= 1'b0;
      r_refresh  <= r_refresh + MUX_BITS'(1);
      r_dig_idx  <= w_idx_next;
      r_digit    <= DIGITS'(1) << w_idx_next;
      r_segments <= w_seg;

      if (period_load) begin
        if (period != '0) r_period <= period;
        r_cycles <= '0;
        r_edges  <= '0;
      end else begin
        case (r_state)
          COUNT: begin
            r_cycles <= r_cycles + PERIOD_BITS'(1);
            r_edges  <= w_edges_inc;
            if (w_terminal) begin
              r_idx      <= LAST_IDX;
              r_ovf_work <= w_ovf_in;
              for (int d = 0; d < 4; d++) r_work[d] <= w_ovf_in ? 4'd9 : 4'd0;
            end
          end
          CONVERT: begin
            if (!r_ovf_work) begin
              if (w_ge) begin
                r_edges        <= r_edges - w_weight;
                r_work[r_idx]  <= r_work[r_idx] + 4'd1;
              end else if (r_idx != 2'd0) begin
                r_idx <= r_idx - 2'd1;
              end
            end
          end
          LATCH: begin
            for (int d = 0; d < 4; d++) r_disp[d] <= r_work[d];
            r_ovf    <= r_ovf_work;
            r_update <= 1'b1;
            r_cycles <= '0;
            r_edges  <= '0;
          end
          default: begin
            r_cycles <= '0;
            r_edges  <= '0;
          end
        endcase
      end
    end
  end

  assign segments = r_segments;
  assign digit    = r_digit;
  assign overflow = r_ovf;
  assign update   = r_update;

endmodule

// File: tb/tb_freq_meter.sv
// Directed self-checking bench for freq_meter (3 digits, fast 4-cycle digit refresh).
module tb_freq_meter;

  localparam logic [6:0] S0 = 7'b0111111;
  localparam logic [6:0] S1 = 7'b0000110;
  localparam logic [6:0] S2 = 7'b1011011;
  localparam logic [6:0] S3 = 7'b1001111;
  localparam logic [6:0] S5 = 7'b1101101;
  localparam logic [6:0] S9 = 7'b1101111;

  logic        clk = 1'b0;
  logic        reset, signal, period_load;
  logic [15:0] period;
  logic [6:0]  segments;
  logic [2:0]  digit;
  logic        overflow, update;

  int n_checks = 0;
  int n_fail   = 0;
  int sig_mode = 0;
  int upd_cnt  = 0;

  freq_meter #(
    .DIGITS(3), .PERIOD_BITS(16), .DEFAULT_PERIOD(1200), .MUX_BITS(2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .signal      (signal),
    .period      (period),
    .period_load (period_load),
    .segments    (segments),
    .digit       (digit),
    .overflow    (overflow),
    .update      (update)
  );

  always #5 clk = ~clk;

  // Stimulus source: 0 = held low, 1 = toggle each cycle, 2 = toggle every 2 cycles.
  initial begin
    int phase;
    phase  = 0;
    signal = 1'b0;
    forever begin
      @(negedge clk);
      phase++;
      case (sig_mode)
        1:       signal = ~signal;
        2:       if (phase % 2 == 0) signal = ~signal;
        default: signal = 1'b0;
      endcase
    end
  end

  always @(negedge clk) if (update === 1'b1) upd_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] p);
    @(negedge clk);
    period      = p;
    period_load = 1'b1;
    @(negedge clk);
    period_load = 1'b0;
  endtask

  task automatic wait_update(input string tag, input int bound, output int n);
    n = 0;
    while (n < bound) begin
      @(negedge clk);
      n++;
      if (update === 1'b1) break;
    end
    check({tag, "_seen"}, 32'(update === 1'b1), 32'd1);
  endtask

  task automatic read_display(output logic [6:0] u, output logic [6:0] t, output logic [6:0] h);
    u = '0; t = '0; h = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      case (digit)
        3'b001: u = segments;
        3'b010: t = segments;
        3'b100: h = segments;
        default: ;
      endcase
    end
  endtask

  task automatic check_display(input string tag, input logic [6:0] eh, input logic [6:0] et,
                               input logic [6:0] eu);
    logic [6:0] u, t, h;
    read_display(u, t, h);
    check({tag, "_units"}, 32'(u), 32'(eu));
    check({tag, "_tens"},  32'(t), 32'(et));
    check({tag, "_hund"},  32'(h), 32'(eh));
  endtask

  initial begin
    int n, snap;
    bit found;
    logic [2:0] prev, exp_dig;
    logic [6:0] exp_seg;

    reset = 1'b1; period = '0; period_load = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_digit",    32'(digit),    32'b001);
    check("rst_segments", 32'(segments), 32'(S0));
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_update",   32'(update),   32'd0);
    reset = 1'b0;

    // 25 edges in a 100-cycle window; conversion 10 cycles -> update 111 cycles after load
    sig_mode = 2;
    repeat (8) @(negedge clk);
    do_load(16'd100);
    wait_update("w100", 400, n);
    check("w100_latency", 32'(n), 32'd111);
    check("w100_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    check("w100_pulse_width", 32'(update), 32'd0);
    check_display("w100", S0, S2, S5);

    // 2000 edges -> saturated 999 with overflow
    sig_mode = 1;
    repeat (8) @(negedge clk);
    do_load(16'd4000);
    wait_update("w4000", 5000, n);
    check("w4000_latency", 32'(n), 32'd4002);
    check("w4000_ovf", 32'(overflow), 32'd1);
    check_display("w4000", S9, S9, S9);

    // exactly 999 edges: largest value without overflow
    do_load(16'd1998);
    wait_update("w1998", 3000, n);
    check("w1998_latency", 32'(n), 32'd2029);
    check("w1998_ovf", 32'(overflow), 32'd0);
    check_display("w1998", S9, S9, S9);

    // signal held low -> 000
    sig_mode = 0;
    repeat (8) @(negedge clk);
    do_load(16'd4000);
    wait_update("wlow", 5000, n);
    check("wlow_latency", 32'(n), 32'd4004);
    check("wlow_ovf", 32'(overflow), 32'd0);
    check_display("wlow", S0, S0, S0);

    // reload mid-window: aborted window latches nothing, display held
    sig_mode = 1;
    repeat (8) @(negedge clk);
    do_load(16'd1200);
    snap = upd_cnt;
    check_display("abort_hold_pre", S0, S0, S0);
    repeat (582) @(negedge clk);
    do_load(16'd50);
    check("abort_no_update", 32'(upd_cnt - snap), 32'd0);
    check_display("abort_hold_post", S0, S0, S0);
    wait_update("w50", 200, n);
    check("w50_latency", 32'(n + 16), 32'd61);
    check_display("w50", S0, S2, S5);

    // 16 cycles into the next window already spent; 34 more lands in CONVERT
    repeat (34) @(negedge clk);
    snap  = upd_cnt;
    reset = 1'b1;
    @(negedge clk);
    check("rconv_digit",    32'(digit),    32'b001);
    check("rconv_segments", 32'(segments), 32'(S0));
    check("rconv_update",   32'(update),   32'd0);
    check("rconv_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    check_display("rconv", S0, S0, S0);
    check("rconv_no_update", 32'(upd_cnt - snap), 32'd0);

    // 123 edges, then watch the digit scan
    repeat (4) @(negedge clk);
    do_load(16'd246);
    wait_update("w246", 400, n);
    check("w246_latency", 32'(n), 32'd256);
    found = 1'b0;
    prev  = digit;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      if (digit == 3'b001 && prev == 3'b100) found = 1'b1;
      prev = digit;
    end
    check("scan_sync", 32'(found), 32'd1);
    for (int i = 0; i < 12; i++) begin
      case (i / 4)
        0:       begin exp_dig = 3'b001; exp_seg = S3; end
        1:       begin exp_dig = 3'b010; exp_seg = S2; end
        default: begin exp_dig = 3'b100; exp_seg = S1; end
      endcase
      check("scan_digit",    32'(digit),    32'(exp_dig));
      check("scan_segments", 32'(segments), 32'(exp_seg));
      @(negedge clk);
    end

    // period 0 is ignored but restarts the window
    do_load(16'd0);
    wait_update("wzero", 400, n);
    check("wzero_latency", 32'(n), 32'd256);
    check("wzero_ovf", 32'(overflow), 32'd0);
    check_display("wzero", S1, S2, S3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 Parameter DIGITS, default 3: number of decimal display digits, legal 2..4.
REQ-002 Parameter PERIOD_BITS, default 16: width of gate-period register, cycle counter and edge counter.
REQ-003 Parameter DEFAULT_PERIOD, default 1200: gate period in clk cycles loaded at reset.
REQ-004 Parameter MUX_BITS, default 8: digit-refresh divider width; active digit advances every 2^MUX_BITS cycles.
REQ-005 clk  input  1  sole clock; all state changes on posedge clk.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 signal  input  1  asynchronous signal under measurement.
REQ-008 period  input  PERIOD_BITS  new gate period in clk cycles.
REQ-009 period_load  input  1  when high, period is captured this cycle.
REQ-010 segments  output  7  active-high segment pattern of the active digit, bit0=a .. bit6=g, registered.
REQ-011 digit  output  DIGITS  one-hot active-high digit select, bit0 = units, registered.
REQ-012 overflow  output  1  high while the displayed result exceeded 10^DIGITS-1.
REQ-013 update  output  1  one-cycle pulse when a new result is latched into the display.

Function
REQ-014 signal SHALL pass a 2-flop synchroniser; an edge SHALL be counted on a 0->1 transition of the synchronised value (3rd flop), at most one per cycle.
REQ-015 FSM states SHALL be COUNT, CONVERT, LATCH; any other encoding SHALL go to COUNT next cycle.
REQ-016 COUNT: cycle counter increments each cycle; edge counter increments on each detected edge; when cycle counter == period_reg-1, go to CONVERT, with an edge detected in that cycle included.
REQ-017 CONVERT: per decade from 10^(DIGITS-1) down to 10^0, subtract the decade weight from the edge counter once per cycle while remainder >= weight, incrementing that BCD digit; then move to next decade, one extra cycle per decade step.
REQ-018 If edge count > 10^DIGITS-1 at CONVERT entry, conversion SHALL be skipped, all BCD digits set to 9 and overflow result set to 1.
REQ-019 LATCH: display digits and overflow updated atomically, update pulses for exactly this cycle, cycle and edge counters cleared, return to COUNT.
REQ-020 Edges occurring in CONVERT or LATCH SHALL be discarded (dead time <= 10*DIGITS+2 cycles).
REQ-021 period_load high: period_reg <= period, counters cleared, state <= COUNT next cycle, display unchanged; period == 0 SHALL be ignored (period_reg kept) but the window still restarts.
REQ-022 period_load and the terminal COUNT cycle coinciding: period_load wins, no result latched.
REQ-023 Refresh counter (MUX_BITS) free-runs; on wrap, digit rotates one-hot units -> tens -> ... -> MSD -> units.
REQ-024 segments SHALL show the BCD digit selected by the next value of digit, so both outputs change in the same cycle; codes 0-9 standard 7-segment, other codes blank (0000000).
REQ-025 Leading zeros SHALL be displayed, not blanked.

Reset
REQ-026 While reset is high: state COUNT, counters and refresh counter 0, period_reg = DEFAULT_PERIOD, all BCD digits 0, overflow 0, update 0, digit = units (one-hot bit0), segments = 0111111 ("0"), synchroniser flops 0.
REQ-027 Reset asserted in any state, including mid-CONVERT, SHALL discard the partial result; first window starts the cycle after reset deasserts.

Structure
REQ-028 Package freq_meter_pkg SHALL hold the FSM state encoding, the 7-segment code table constants and a decade-weight function 10^n.
REQ-029 Sub-module seven_segment (4-bit BCD in, 7-bit pattern out, combinational) SHALL be instantiated once, after the digit mux.

Verification
REQ-030 Reset, period_load=1 period=100, signal toggled every 2 cycles (25 rising edges per window) -> update pulse, displayed digits 0,2,5, overflow 0.
REQ-031 DIGITS=3, period=4000, signal toggled every cycle (2000 edges) -> digits 9,9,9, overflow 1; next window with signal held low -> 0,0,0, overflow 0.
REQ-032 period_load (period=50) in cycle 600 of a 1200-cycle window -> no update for that window, next update exactly 50+conversion+1 cycles later, display held meanwhile.
REQ-033 Reset pulsed during CONVERT -> no update pulse, display 0,0,0, digit=001, segments=0111111 next cycle.
REQ-034 MUX_BITS=2, display 1,2,3 -> digit cycles 001,010,100 every 4 clk cycles with segments 0000110, 1011011, 1001111 in matching cycles.
REQ-035 period=0 load -> period_reg unchanged, window restarts, next result identical to prior-period measurement.
